// File: rtl/paint_pkg.sv
// Shared definitions for the VGA index RAM path: screen geometry, packed
// write-word layout and the fill engine state encoding.
package paint_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int ADDR_W   = 19;
    localparam int INDEX_W  = 8;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;
    localparam int DATA_W   = 32;
    localparam int ADDR_LSB = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

    // y*640 built from two shifts (512 + 128) so no multiplier is needed.
    function automatic logic [ADDR_W-1:0] row_base_of(input logic [Y_W-1:0] y);
        logic [ADDR_W-1:0] ye;
        ye = ADDR_W'(y);
        return (ye << 9) + (ye << 7);
    endfunction

endpackage

// File: rtl/raster_addr_gen.sv
// Raster-order address walker over an inclusive rectangle. Holds the x/y
// position, the running row base and the rectangle bounds.
module raster_addr_gen
    import paint_pkg::*;
(
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [X_W-1:0]    xl_i,
    input  logic [X_W-1:0]    xr_i,
    input  logic [Y_W-1:0]    yt_i,
    input  logic [Y_W-1:0]    yb_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [X_W-1:0]    x_q, x_d, xl_q, xl_d, xr_q, xr_d;
    logic [Y_W-1:0]    y_q, y_d, yb_q, yb_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;

    assign addr_o = row_base_q + ADDR_W'(x_q);
    assign last_o = (x_q == xr_q) && (y_q == yb_q);

    // Load the rectangle origin, or advance one pixel in raster order.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        xl_d       = xl_q;
        xr_d       = xr_q;
        yb_d       = yb_q;
        row_base_d = row_base_q;
        if (load_i) begin
            xl_d       = xl_i;
            xr_d       = xr_i;
            yb_d       = yb_i;
            x_d        = xl_i;
            y_d        = yt_i;
            row_base_d = row_base_of(yt_i);
        end else if (step_i && !last_o) begin
            if (x_q < xr_q) begin
                x_d = x_q + 1'b1;
            end else begin
                x_d        = xl_q;
                y_d        = y_q + 1'b1;
                row_base_d = row_base_q + ADDR_W'(H_ACTIVE);
            end
        end
    end

    // Counter and bound registers.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            x_q        <= '0;
            y_q        <= '0;
            xl_q       <= '0;
            xr_q       <= '0;
            yb_q       <= '0;
            row_base_q <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            xl_q       <= xl_d;
            xr_q       <= xr_d;
            yb_q       <= yb_d;
            row_base_q <= row_base_d;
        end
    end

endmodule

// File: rtl/index_fill_writer.sv
// Rectangle-fill engine: accepts fill commands and streams one index-RAM
// write per pixel clock in raster order as {addr, index} packed words.
module index_fill_writer
    import paint_pkg::*;
(
    input  logic               iVGA_CLK,
    input  logic               iRST_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [X_W-1:0]     cmd_x0,
    input  logic [Y_W-1:0]     cmd_y0,
    input  logic [X_W-1:0]     cmd_x1,
    input  logic [Y_W-1:0]     cmd_y1,
    input  logic [INDEX_W-1:0] cmd_index,
    input  logic               cmd_abort,
    output logic [DATA_W-1:0]  data_index_out,
    output logic               ctrl_index_write_enable,
    output logic               busy,
    output logic               done
);

    fill_state_e        state_q, state_d;
    logic               we_q, we_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic               last_seen_q, last_seen_d;

    logic [X_W-1:0]     cx0, cx1, xl, xr;
    logic [Y_W-1:0]     cy0, cy1, yt, yb;
    logic               load, step, last;
    logic [ADDR_W-1:0]  addr;

    // Clamp corners to the visible area and order them into left/right, top/bottom.
    always_comb begin
        cx0 = (cmd_x0 > X_W'(H_ACTIVE - 1)) ? X_W'(H_ACTIVE - 1) : cmd_x0;
        cx1 = (cmd_x1 > X_W'(H_ACTIVE - 1)) ? X_W'(H_ACTIVE - 1) : cmd_x1;
        cy0 = (cmd_y0 > Y_W'(V_ACTIVE - 1)) ? Y_W'(V_ACTIVE - 1) : cmd_y0;
        cy1 = (cmd_y1 > Y_W'(V_ACTIVE - 1)) ? Y_W'(V_ACTIVE - 1) : cmd_y1;
        xl  = (cx0 <= cx1) ? cx0 : cx1;
        xr  = (cx0 <= cx1) ? cx1 : cx0;
        yt  = (cy0 <= cy1) ? cy0 : cy1;
        yb  = (cy0 <= cy1) ? cy1 : cy0;
    end

    raster_addr_gen u_gen (
        .iVGA_CLK (iVGA_CLK),
        .iRST_n   (iRST_n),
        .load_i   (load),
        .step_i   (step),
        .xl_i     (xl),
        .xr_i     (xr),
        .yt_i     (yt),
        .yb_i     (yb),
        .addr_o   (addr),
        .last_o   (last)
    );

    // Next state, write strobe and packed word; a pixel is presented each FILL
    // edge until the last one has been shown or an abort is sampled.
    always_comb begin
        state_d     = state_q;
        we_d        = 1'b0;
        data_d      = data_q;
        index_d     = index_q;
        last_seen_d = last_seen_q;
        load        = 1'b0;
        step        = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (cmd_valid) begin
                    load        = 1'b1;
                    index_d     = cmd_index;
                    last_seen_d = 1'b0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                if (cmd_abort || last_seen_q) begin
                    state_d = DONE;
                end else begin
                    we_d        = 1'b1;
                    data_d      = (DATA_W'(addr) << ADDR_LSB) | DATA_W'(index_q);
                    step        = 1'b1;
                    last_seen_d = last;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered output stage.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            data_q      <= '0;
            index_q     <= '0;
            last_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            data_q      <= data_d;
            index_q     <= index_d;
            last_seen_q <= last_seen_d;
        end
    end

    assign cmd_ready               = (state_q != FILL);
    assign busy                    = (state_q == FILL);
    assign done                    = (state_q == DONE);
    assign ctrl_index_write_enable = we_q;
    assign data_index_out          = data_q;

endmodule

// File: tb/tb_index_fill_writer.sv
// Self-checking bench for index_fill_writer with a queue-based raster model.
module tb_index_fill_writer;

    logic        iVGA_CLK = 1'b0;
    logic        iRST_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x0 = '0;
    logic [8:0]  cmd_y0 = '0;
    logic [9:0]  cmd_x1 = '0;
    logic [8:0]  cmd_y1 = '0;
    logic [7:0]  cmd_index = '0;
    logic        cmd_abort = 1'b0;
    logic [31:0] data_index_out;
    logic        ctrl_index_write_enable;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int doneCount = 0;
    int doneCycle = 0;
    logic [31:0] got[$];
    logic [31:0] expq[$];
    int weCycle[$];

    index_fill_writer dut (
        .iVGA_CLK                (iVGA_CLK),
        .iRST_n                  (iRST_n),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_x0                  (cmd_x0),
        .cmd_y0                  (cmd_y0),
        .cmd_x1                  (cmd_x1),
        .cmd_y1                  (cmd_y1),
        .cmd_index               (cmd_index),
        .cmd_abort               (cmd_abort),
        .data_index_out          (data_index_out),
        .ctrl_index_write_enable (ctrl_index_write_enable),
        .busy                    (busy),
        .done                    (done)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    // Cycle counter used to timestamp writes and done pulses.
    always @(posedge iVGA_CLK) cycle <= cycle + 1;

    // Capture every write and done pulse on the falling edge.
    always @(negedge iVGA_CLK) begin
        if (ctrl_index_write_enable) begin
            got.push_back(data_index_out);
            weCycle.push_back(cycle);
        end
        if (done) begin
            doneCount++;
            doneCycle = cycle;
        end
    end

    // Reference: clamp, order, then enumerate pixels row by row.
    function automatic void model_fill(input int x0, input int y0, input int x1, input int y1, input int idx);
        int ax, bx, ay, by, xl, xr, yt, yb;
        ax = (x0 > 639) ? 639 : x0;
        bx = (x1 > 639) ? 639 : x1;
        ay = (y0 > 479) ? 479 : y0;
        by = (y1 > 479) ? 479 : y1;
        xl = (ax < bx) ? ax : bx;
        xr = (ax < bx) ? bx : ax;
        yt = (ay < by) ? ay : by;
        yb = (ay < by) ? by : ay;
        for (int y = yt; y <= yb; y++)
            for (int x = xl; x <= xr; x++)
                expq.push_back(32'((y * 640 + x) * 256 + idx));
    endfunction

    task automatic clear_capture();
        got.delete();
        weCycle.delete();
        expq.delete();
        doneCount = 0;
    endtask

    task automatic send_cmd(input int x0, input int y0, input int x1, input int y1, input int idx,
                            output bit timedOut);
        int n;
        @(negedge iVGA_CLK);
        cmd_x0 = 10'(x0);
        cmd_y0 = 9'(y0);
        cmd_x1 = 10'(x1);
        cmd_y1 = 9'(y1);
        cmd_index = 8'(idx);
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge iVGA_CLK);
            n++;
        end
        timedOut = !cmd_ready;
        @(posedge iVGA_CLK);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, output bit timedOut);
        int n;
        n = 0;
        while (doneCount < target && n < budget) begin
            @(negedge iVGA_CLK);
            #1;
            n++;
        end
        timedOut = (doneCount < target);
    endtask

    task automatic do_fill(input int x0, input int y0, input int x1, input int y1, input int idx,
                           input int budget, output bit timedOut);
        bit t1, t2;
        clear_capture();
        model_fill(x0, y0, x1, y1, idx);
        send_cmd(x0, y0, x1, y1, idx, t1);
        wait_done(1, budget, t2);
        timedOut = t1 || t2;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge iVGA_CLK);
        #1;
        checks++;
        if ({cmd_ready, busy, done, ctrl_index_write_enable} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 1000", {cmd_ready, busy, done, ctrl_index_write_enable});
        end
        checks++;
        if (data_index_out !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h expected 00000000", data_index_out);
        end
        @(negedge iVGA_CLK);
        iRST_n = 1'b1;
        @(negedge iVGA_CLK);
        #1;
        checks++;
        if ({cmd_ready, busy, done, ctrl_index_write_enable} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got %b expected 1000", {cmd_ready, busy, done, ctrl_index_write_enable});
        end
    endtask

    task automatic test_single_pixel();
        bit to;
        do_fill(5, 3, 5, 3, 8'h2A, 50, to);
        checks++;
        if (to) begin
            errors++;
            $display("[TB] FAIL single_timeout: got timeout expected done");
        end
        checks++;
        if (got.size() != 1) begin
            errors++;
            $display("[TB] FAIL single_count: got %0d expected 1", got.size());
        end else begin
            checks++;
            if (got[0] !== 32'h0007852A) begin
                errors++;
                $display("[TB] FAIL single_word: got %h expected 0007852a", got[0]);
            end
            checks++;
            if (doneCycle != weCycle[0] + 1) begin
                errors++;
                $display("[TB] FAIL single_done_cycle: got %0d expected %0d", doneCycle, weCycle[0] + 1);
            end
        end
        @(negedge iVGA_CLK);
        #1;
        checks++;
        if (done !== 1'b0 || doneCount != 1) begin
            errors++;
            $display("[TB] FAIL single_done_width: got done=%b count=%0d expected done=0 count=1", done, doneCount);
        end
    endtask

    task automatic test_corner();
        bit to;
        int want[4];
        want = '{306558, 306559, 307198, 307199};
        do_fill(638, 478, 639, 479, 8'h11, 50, to);
        checks++;
        if (to || got.size() != 4) begin
            errors++;
            $display("[TB] FAIL corner_count: got %0d expected 4 (timeout=%0d)", got.size(), to);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== 32'(want[i] * 256 + 8'h11)) begin
                    errors++;
                    $display("[TB] FAIL corner_word%0d: got %h expected %h", i, got[i], 32'(want[i] * 256 + 8'h11));
                end
            end
        end
    endtask

    task automatic test_swap_clamp();
        bit to;
        do_fill(10, 0, 8, 0, 8'h05, 50, to);
        checks++;
        if (to || got.size() != 3) begin
            errors++;
            $display("[TB] FAIL swap_count: got %0d expected 3 (timeout=%0d)", got.size(), to);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== 32'((8 + i) * 256 + 5)) begin
                    errors++;
                    $display("[TB] FAIL swap_word%0d: got %h expected %h", i, got[i], 32'((8 + i) * 256 + 5));
                end
            end
        end
        do_fill(636, 500, 1000, 500, 8'hC3, 50, to);
        checks++;
        if (to || got.size() != 4) begin
            errors++;
            $display("[TB] FAIL clamp_count: got %0d expected 4 (timeout=%0d)", got.size(), to);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== 32'((307196 + i) * 256 + 8'hC3)) begin
                    errors++;
                    $display("[TB] FAIL clamp_word%0d: got %h expected %h", i, got[i], 32'((307196 + i) * 256 + 8'hC3));
                end
            end
        end
    endtask

    task automatic test_random();
        bit to;
        int x0, y0, x1, y1, idx, bad;
        for (int t = 0; t < 12; t++) begin
            x0 = $urandom_range(0, 700);
            y0 = $urandom_range(0, 511);
            x1 = x0 + $urandom_range(0, 30) - 15;
            y1 = y0 + $urandom_range(0, 8) - 4;
            if (x1 < 0) x1 = 0;
            if (x1 > 1023) x1 = 1023;
            if (y1 < 0) y1 = 0;
            if (y1 > 511) y1 = 511;
            idx = $urandom_range(0, 255);
            do_fill(x0, y0, x1, y1, idx, 2000, to);
            checks++;
            if (to || got.size() != expq.size()) begin
                errors++;
                $display("[TB] FAIL random%0d_count: got %0d expected %0d (timeout=%0d)", t, got.size(), expq.size(), to);
            end else begin
                bad = 0;
                for (int i = 0; i < expq.size(); i++)
                    if (got[i] !== expq[i]) bad++;
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("[TB] FAIL random%0d_words: got %0d wrong words expected 0 (first got %h expected %h)",
                             t, bad, got[0], expq[0]);
                end
            end
        end
    endtask

    task automatic test_abort();
        bit to;
        int n;
        clear_capture();
        send_cmd(0, 0, 99, 0, 8'h77, to);
        n = 0;
        while (got.size() < 3 && n < 50) begin
            @(negedge iVGA_CLK);
            #1;
            n++;
        end
        cmd_abort = 1'b1;
        @(posedge iVGA_CLK);
        #1 cmd_abort = 1'b0;
        wait_done(1, 50, to);
        checks++;
        if (to || got.size() != 3) begin
            errors++;
            $display("[TB] FAIL abort_count: got %0d expected 3 (timeout=%0d)", got.size(), to);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== 32'(i * 256 + 8'h77)) begin
                    errors++;
                    $display("[TB] FAIL abort_word%0d: got %h expected %h", i, got[i], 32'(i * 256 + 8'h77));
                end
            end
        end
        checks++;
        if (cmd_ready !== 1'b1 || doneCount != 1) begin
            errors++;
            $display("[TB] FAIL abort_done: got ready=%b count=%0d expected ready=1 count=1", cmd_ready, doneCount);
        end
        repeat (3) @(negedge iVGA_CLK);
        #1;
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("[TB] FAIL abort_no_more: got %0d expected 3", got.size());
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int n, n1, bad;
        clear_capture();
        model_fill(20, 10, 24, 11, 8'hA1);
        n1 = expq.size();
        model_fill(0, 5, 2, 5, 8'hB2);
        @(negedge iVGA_CLK);
        cmd_x0 = 10'd20; cmd_y0 = 9'd10; cmd_x1 = 10'd24; cmd_y1 = 9'd11; cmd_index = 8'hA1;
        cmd_valid = 1'b1;
        @(posedge iVGA_CLK);
        #1;
        cmd_x0 = 10'd0; cmd_y0 = 9'd5; cmd_x1 = 10'd2; cmd_y1 = 9'd5; cmd_index = 8'hB2;
        @(negedge iVGA_CLK);
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge iVGA_CLK);
            n++;
        end
        @(posedge iVGA_CLK);
        #1 cmd_valid = 1'b0;
        wait_done(2, 100, to);
        checks++;
        if (to || got.size() != expq.size()) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d expected %0d (timeout=%0d)", got.size(), expq.size(), to);
        end else begin
            bad = 0;
            for (int i = 0; i < expq.size(); i++)
                if (got[i] !== expq[i]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("[TB] FAIL b2b_words: got %0d wrong words expected 0", bad);
            end
            checks++;
            if (weCycle[n1] - weCycle[n1 - 1] != 3) begin
                errors++;
                $display("[TB] FAIL b2b_gap: got %0d idle cycles expected 2", weCycle[n1] - weCycle[n1 - 1] - 1);
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        bit to;
        int n;
        clear_capture();
        send_cmd(0, 0, 639, 479, 8'h3C, to);
        n = 0;
        while (got.size() < 1000 && n < 2000) begin
            @(negedge iVGA_CLK);
            #1;
            n++;
        end
        checks++;
        if (got.size() != 1000) begin
            errors++;
            $display("[TB] FAIL rst_reach1000: got %0d expected 1000", got.size());
        end
        iRST_n = 1'b0;
        #1;
        checks++;
        if ({ctrl_index_write_enable, busy, done, cmd_ready} !== 4'b0001 || data_index_out !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_async: got we/busy/done/ready=%b data=%h expected 0001 00000000",
                     {ctrl_index_write_enable, busy, done, cmd_ready}, data_index_out);
        end
        repeat (3) @(negedge iVGA_CLK);
        #1;
        checks++;
        if (got.size() != 1000 || doneCount != 0) begin
            errors++;
            $display("[TB] FAIL rst_quiet: got writes=%0d dones=%0d expected 1000 0", got.size(), doneCount);
        end
        @(negedge iVGA_CLK);
        iRST_n = 1'b1;
        @(negedge iVGA_CLK);
    endtask

    task automatic test_large();
        bit to;
        int bad;
        do_fill(0, 400, 639, 479, 8'h9E, 60000, to);
        checks++;
        if (to || got.size() != 51200) begin
            errors++;
            $display("[TB] FAIL large_count: got %0d expected 51200 (timeout=%0d)", got.size(), to);
        end else begin
            checks++;
            if (got[51199][31:8] !== 24'd307199) begin
                errors++;
                $display("[TB] FAIL large_last: got %0d expected 307199", got[51199][31:8]);
            end
            bad = 0;
            for (int i = 0; i < 51200; i++)
                if (got[i] !== expq[i]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("[TB] FAIL large_words: got %0d wrong words expected 0", bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_corner();
        test_swap_clamp();
        test_random();
        test_abort();
        test_back_to_back();
        test_reset_mid_fill();
        test_large();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
